// File: rtl/decode_issue_queue.sv
// Dual-lane circular instruction queue between fetch and the two decode lanes.
// Pushes up to two fetched instructions per cycle; issues up to two in order, serializing solo-class entries.
module decode_issue_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [1:0]              in_valid,
    input  logic [31:0]             in_pc0,
    input  logic [31:0]             in_pc1,
    input  logic [31:0]             in_inst0,
    input  logic [31:0]             in_inst1,
    input  logic [1:0]              in_excp,
    input  logic [6:0]              in_excp_cause0,
    input  logic [6:0]              in_excp_cause1,
    output logic                    in_ready,
    input  logic                    dispatch_stall,
    output logic [1:0]              out_valid,
    output logic [31:0]             out_pc0,
    output logic [31:0]             out_pc1,
    output logic [31:0]             out_inst0,
    output logic [31:0]             out_inst1,
    output logic [1:0]              out_excp,
    output logic [6:0]              out_excp_cause0,
    output logic [6:0]              out_excp_cause1,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      inst_mem  [DEPTH];
    logic [6:0]       cause_mem [DEPTH];
    logic [DEPTH-1:0] excp_mem;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr1;
    logic [AW-1:0] rd_ptr1;
    logic          push_en;
    logic [1:0]    npush;
    logic [1:0]    npop;
    logic          head_solo;
    logic          next_solo;

    // CSR access, privileged (ertn/idle/tlb group) and faulting entries must issue alone.
    function automatic logic is_solo(input logic excp, input logic [31:0] inst);
        return excp || (inst[31:24] == 8'h04) || (inst[31:22] == 10'b0000011001);
    endfunction

    assign wr_ptr1  = wr_ptr + AW'(1);
    assign rd_ptr1  = rd_ptr + AW'(1);
    assign in_ready = (count <= CW'(DEPTH - 2));
    assign push_en  = in_ready && !flush;

    assign head_solo = is_solo(excp_mem[rd_ptr], inst_mem[rd_ptr]);
    assign next_solo = is_solo(excp_mem[rd_ptr1], inst_mem[rd_ptr1]);

    always_comb begin
        out_valid       = 2'b00;
        out_valid[0]    = (count != '0) && !flush;
        out_valid[1]    = (count >= CW'(2)) && !flush && !head_solo && !next_solo;
        out_pc0         = pc_mem[rd_ptr];
        out_pc1         = pc_mem[rd_ptr1];
        out_inst0       = inst_mem[rd_ptr];
        out_inst1       = inst_mem[rd_ptr1];
        out_excp        = {excp_mem[rd_ptr1], excp_mem[rd_ptr]};
        out_excp_cause0 = cause_mem[rd_ptr];
        out_excp_cause1 = cause_mem[rd_ptr1];
    end

    always_comb begin
        npush = 2'd0;
        npop  = 2'd0;
        if (push_en) begin
            npush = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
        end
        if (!dispatch_stall) begin
            npop = out_valid[1] ? 2'd2 : (out_valid[0] ? 2'd1 : 2'd0);
        end
    end

    // Lanes are compacted: the first valid lane always lands at wr_ptr.
    always_ff @(posedge clk) begin
        if (push_en && !rst && (in_valid != 2'b00)) begin
            pc_mem[wr_ptr]    <= in_valid[0] ? in_pc0 : in_pc1;
            inst_mem[wr_ptr]  <= in_valid[0] ? in_inst0 : in_inst1;
            excp_mem[wr_ptr]  <= in_valid[0] ? in_excp[0] : in_excp[1];
            cause_mem[wr_ptr] <= in_valid[0] ? in_excp_cause0 : in_excp_cause1;
        end
        if (push_en && !rst && (in_valid == 2'b11)) begin
            pc_mem[wr_ptr1]    <= in_pc1;
            inst_mem[wr_ptr1]  <= in_inst1;
            excp_mem[wr_ptr1]  <= in_excp[1];
            cause_mem[wr_ptr1] <= in_excp_cause1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(npush);
            rd_ptr <= rd_ptr + AW'(npop);
            count  <= count + CW'(npush) - CW'(npop);
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Randomized self-checking bench for decode_issue_queue against a queue-based reference model.
module tb_decode_issue_queue;
    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic [6:0]  cause;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_pc0, in_pc1, in_inst0, in_inst1;
    logic [1:0]  in_excp;
    logic [6:0]  in_excp_cause0, in_excp_cause1;
    logic        in_ready;
    logic        dispatch_stall;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1;
    logic [1:0]  out_excp;
    logic [6:0]  out_excp_cause0, out_excp_cause1;
    logic [3:0]  count;

    ent_t        mq[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    decode_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc0(in_pc0), .in_pc1(in_pc1),
        .in_inst0(in_inst0), .in_inst1(in_inst1), .in_excp(in_excp),
        .in_excp_cause0(in_excp_cause0), .in_excp_cause1(in_excp_cause1),
        .in_ready(in_ready), .dispatch_stall(dispatch_stall),
        .out_valid(out_valid), .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_inst0(out_inst0), .out_inst1(out_inst1), .out_excp(out_excp),
        .out_excp_cause0(out_excp_cause0), .out_excp_cause1(out_excp_cause1),
        .count(count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit solo(input ent_t e);
        return e.excp || (e.inst[31:24] == 8'h04) || (e.inst[31:22] == 10'b0000011001);
    endfunction

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic excp, input logic [6:0] cause);
        ent_t e;
        e.pc = pc; e.inst = inst; e.excp = excp; e.cause = cause;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        int unsigned k;
        k = $urandom_range(0, 9);
        e.pc = $urandom & 32'hFFFF_FFFC;
        if (k == 0)      e.inst = {8'h04, 24'($urandom)};
        else if (k == 1) e.inst = {10'b0000011001, 22'($urandom)};
        else             e.inst = $urandom;
        e.excp  = ($urandom_range(0, 9) == 0);
        e.cause = 7'($urandom);
        return e;
    endfunction

    task automatic drive_idle();
        flush = 1'b0; dispatch_stall = 1'b0; in_valid = 2'b00;
        in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0;
        in_excp = 2'b00; in_excp_cause0 = '0; in_excp_cause1 = '0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic fl, input logic st, input logic [1:0] v,
                        input ent_t e0, input ent_t e1);
        int unsigned sz;
        logic        exp_ready;
        logic [1:0]  exp_ov;
        flush = fl; dispatch_stall = st; in_valid = v;
        in_pc0 = e0.pc; in_inst0 = e0.inst; in_excp[0] = e0.excp; in_excp_cause0 = e0.cause;
        in_pc1 = e1.pc; in_inst1 = e1.inst; in_excp[1] = e1.excp; in_excp_cause1 = e1.cause;
        #1;
        sz = mq.size();
        exp_ready = (DEPTH - sz) >= 2;
        exp_ov = 2'b00;
        if (sz >= 1 && !fl) exp_ov[0] = 1'b1;
        if (sz >= 2 && !fl) exp_ov[1] = !solo(mq[0]) && !solo(mq[1]);
        check_eq("count", count, sz);
        check_eq("in_ready", in_ready, exp_ready);
        check_eq("out_valid", out_valid, exp_ov);
        if (exp_ov[0]) begin
            check_eq("out_pc0", out_pc0, mq[0].pc);
            check_eq("out_inst0", out_inst0, mq[0].inst);
            check_eq("out_excp0", out_excp[0], mq[0].excp);
            check_eq("out_cause0", out_excp_cause0, mq[0].cause);
        end
        if (exp_ov[1]) begin
            check_eq("out_pc1", out_pc1, mq[1].pc);
            check_eq("out_inst1", out_inst1, mq[1].inst);
            check_eq("out_excp1", out_excp[1], mq[1].excp);
            check_eq("out_cause1", out_excp_cause1, mq[1].cause);
        end
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (!st) begin
                if (exp_ov[0]) void'(mq.pop_front());
                if (exp_ov[1]) void'(mq.pop_front());
            end
            if (exp_ready) begin
                if (v[0]) mq.push_back(e0);
                if (v[1]) mq.push_back(e1);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        #2;
        mq.delete();
        check_eq("rst_count", count, 0);
        check_eq("rst_ready", in_ready, 1);
        check_eq("rst_valid", out_valid, 2'b00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    ent_t z;
    ent_t a, b;

    initial begin
        z = '0;
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        do_reset();

        // Two addi.w pushed together, then issued together.
        step(0, 0, 2'b11, mk(32'h1c00_0000, 32'h0280_0421, 0, 0), mk(32'h1c00_0004, 32'h0280_0842, 0, 0));
        check_eq("pair_count", count, 2);
        check_eq("pair_valid", out_valid, 2'b11);
        check_eq("pair_pc0", out_pc0, 32'h1c00_0000);
        check_eq("pair_pc1", out_pc1, 32'h1c00_0004);
        step(0, 0, 2'b00, z, z);
        step(0, 0, 2'b00, z, z);

        // Fill under stall; the fifth dual push is dropped.
        for (int i = 0; i < 5; i++) step(0, 1, 2'b11, rand_ent(), rand_ent());
        check_eq("full_count", count, DEPTH);
        check_eq("full_ready", in_ready, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 2'b00, z, z);

        // csrrd at head followed by ori; lane0 fetch exception issues alone.
        step(0, 1, 2'b11, mk(32'h1c00_0100, 32'h0400_0004, 0, 0), mk(32'h1c00_0104, 32'h0380_0000, 0, 0));
        check_eq("csr_valid", out_valid, 2'b01);
        step(0, 0, 2'b01, mk(32'h1c00_0108, 32'h0280_0000, 1, 7'h08), z);
        step(0, 0, 2'b00, z, z);
        check_eq("excp_valid", out_valid, 2'b01);
        check_eq("excp_flag", out_excp[0], 1);
        check_eq("excp_cause", out_excp_cause0, 7'h08);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b00, z, z);

        // Walk both pointers to 7, then a dual push/pop across the wrap.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 2'b01, mk(32'h2000_0000 + 4 * i, 32'h0280_0000, 0, 0), z);
            step(0, 0, 2'b00, z, z);
        end
        a = mk(32'h3000_0000, 32'h0280_0001, 0, 0);
        b = mk(32'h3000_0004, 32'h0280_0002, 0, 0);
        step(0, 1, 2'b11, a, b);
        check_eq("wrap_valid", out_valid, 2'b11);
        check_eq("wrap_pc0", out_pc0, 32'h3000_0000);
        check_eq("wrap_pc1", out_pc1, 32'h3000_0004);
        step(0, 0, 2'b00, z, z);
        step(0, 0, 2'b00, z, z);

        // Flush at count 5 beats a simultaneous push and pop.
        step(0, 1, 2'b11, rand_ent(), rand_ent());
        step(0, 1, 2'b11, rand_ent(), rand_ent());
        step(0, 1, 2'b01, rand_ent(), z);
        check_eq("pre_flush_count", count, 5);
        step(1, 0, 2'b11, rand_ent(), rand_ent());
        check_eq("flush_count", count, 0);
        check_eq("flush_ready", in_ready, 1);

        // Reset asserted mid-push clears state immediately.
        step(0, 1, 2'b11, rand_ent(), rand_ent());
        a = rand_ent();
        in_valid = 2'b11; in_pc0 = a.pc; in_inst0 = a.inst;
        #2 rst = 1'b1;
        #1;
        mq.delete();
        check_eq("async_count", count, 0);
        check_eq("async_valid", out_valid, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        step(0, 0, 2'b00, z, z);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                 2'($urandom), rand_ent(), rand_ent());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Dual-lane instruction buffer and issue controller between instruction fetch and the two decode lanes (each lane a bank of format decoders: 2RI12, 3R, etc.). Accepts up to two fetched instructions per cycle, holds them in a circular queue, and presents up to two per cycle to the decoders in program order. Serializes privileged, CSR and faulting instructions to issue alone. Absorbs dispatch stalls and clears on pipeline flush.

## Interface
- DEPTH, 8, queue entries; power of two, ≥4
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all queued entries and this cycle's push
- in_valid  in  2  per-lane fetch valid; bit0 = older instruction
- in_pc0, in_pc1  in  32  fetch PCs
- in_inst0, in_inst1  in  32  fetch instruction words
- in_excp  in  2  per-lane fetch exception flag (e.g. ADEF)
- in_excp_cause0, in_excp_cause1  in  7  exception cause code
- in_ready  out  1  queue can accept two instructions this cycle
- dispatch_stall  in  1  downstream cannot take any instruction this cycle
- out_valid  out  2  per-lane issue valid to decoders
- out_pc0, out_pc1  out  32  PCs of head, head+1
- out_inst0, out_inst1  out  32  instruction words of head, head+1
- out_excp  out  2  exception flags of head, head+1
- out_excp_cause0, out_excp_cause1  out  7  exception causes
- count  out  log2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH entries of {pc, inst, excp, cause}; wr_ptr, rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH; count tracked separately (0..DEPTH).
- in_ready = (DEPTH − count) ≥ 2, from registered count only; a same-cycle pop does not raise it.
- Push (in_ready && !flush): valid lanes written in order, lane0 first then lane1, compacted; in_valid=2'b10 writes lane1 at wr_ptr. npush = popcount(in_valid). Push with in_ready=0 is dropped; fetch must hold.
- Solo class for an entry: excp=1, or inst[31:24]=8'h04 (csrrd/csrwr/csrxchg), or inst[31:22]=10'b0000011001 (ertn/idle/tlb/invtlb group).
- out_valid[0] = count≥1 && !flush.
- out_valid[1] = count≥2 && !flush && neither head nor head+1 is solo class.
- out_* data always driven from entries rd_ptr and rd_ptr+1 (mod DEPTH); data undefined when the matching out_valid=0.
- Pop: npop = dispatch_stall ? 0 : popcount(out_valid); rd_ptr += npop.
- count_next = count + npush − npop; simultaneous push and pop in one cycle are legal.
- Flush: next cycle wr_ptr=rd_ptr=count=0; same-cycle push and pop are discarded. Flush has priority over push, pop and stall.

## Timing
- Reset (async assert): wr_ptr=0, rd_ptr=0, count=0 → out_valid=2'b00, in_ready=1; stored entry contents not reset.
- Write-to-issue latency: 1 cycle (entry pushed at edge N visible on out_* after edge N).
- Outputs are combinational from registered state plus flush; no input-to-output path except flush → out_valid.
- Full: count=DEPTH → in_ready=0; count=DEPTH−1 → in_ready=0 (two-slot rule).
- Empty: count=0 → out_valid=0 regardless of stall.
- Wrap-around: head at DEPTH−1 pairs with entry 0 as head+1; a two-lane push at wr_ptr=DEPTH−1 writes entries DEPTH−1 and 0.
- Reset asserted mid-push or mid-pop: state clears immediately; nothing from that cycle is retained.

## Test plan
- Reset then push in_valid=2'b11, pc 0x1c000000/0x1c000004, two addi.w → next cycle out_valid=2'b11 with those PCs, count=2; pop → count=0.
- Fill DEPTH=8 with stall held: after 3 dual pushes count=6, in_ready=1; after 4th count=8, in_ready=0; a 5th push is dropped, count stays 8.
- Head is csrrd (inst 0x04000004) followed by ori → out_valid=2'b01 first cycle, then ori issues alone or pairs with the next entry.
- Lane0 push with in_excp=1, cause 7'h08 → issues alone with out_excp[0]=1, out_excp_cause0=7'h08.
- Wrap: rd_ptr=wr_ptr=7, push two then pop two → entries 7 and 0 issue in order, both pointers end at 1.
- Flush with count=5 plus simultaneous push 2'b11 and pop → out_valid=0 that cycle, count=0 next cycle, in_ready=1.
